rc4_key_cycle: RTL and testbench
================================

RC4_KEY_CYCLE -- requirements
Module: rc4_key_cycle

Interface
REQ-001 Parameter: KEY_MAX, default 24'h3FFFFF, last key tried before declaring no solution.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  level request to begin the key search from IDLE.
REQ-005 enable  input  1  global run enable; low freezes the FSM and key.
REQ-006 dc_done  input  1  decrypt core finished and the result is valid.
REQ-007 dc_invalid  input  1  decrypt core rejected the current key.
REQ-008 sc_key  output  24  candidate key presented to the decrypt core.
REQ-009 reset_decrypt  output  1  reset pulse to the decrypt core.
REQ-010 start_decrypt  output  1  run request to the decrypt core.
REQ-011 no_sol  output  1  keyspace exhausted without a valid key.

Function
REQ-012 State register SHALL be 7 bits, one-hot-free encoding: IDLE=000_0000, RESET_MANUAL=001_0001, WAIT_DECRYPT=010_0010, KEY_INC=000_0011, RESET_DECRYPT=001_0100, DONE=000_0101, CHK_KEY=000_0111, NO_SOL=100_1000.
REQ-013 Outputs SHALL be decoded directly from state bits: no_sol=state[6], start_decrypt=state[5], reset_decrypt=state[4] (glitch-free, no combinational logic on inputs).
REQ-014 sc_key SHALL be a 24-bit register driven unchanged onto the output.
REQ-015 When enable=0, state and sc_key SHALL hold their values; all transitions below apply only when enable=1.
REQ-016 IDLE: start=1 -> RESET_MANUAL; else stay.
REQ-017 RESET_MANUAL: sc_key <= 0; -> WAIT_DECRYPT unconditionally.
REQ-018 WAIT_DECRYPT: dc_invalid=1 -> CHK_KEY; else dc_done=1 -> DONE; else stay. dc_invalid SHALL take priority when both are high.
REQ-019 CHK_KEY: sc_key==KEY_MAX -> NO_SOL; else -> KEY_INC.
REQ-020 KEY_INC: sc_key <= sc_key+1; -> RESET_DECRYPT.
REQ-021 RESET_DECRYPT: -> WAIT_DECRYPT unconditionally.
REQ-022 DONE and NO_SOL SHALL be terminal; exit only via reset. sc_key SHALL hold the found or last key.
REQ-023 Each rejected key SHALL cost exactly 4 cycles (WAIT_DECRYPT, CHK_KEY, KEY_INC, RESET_DECRYPT), plus the core's own latency in WAIT_DECRYPT.
REQ-024 sc_key SHALL never exceed KEY_MAX; the increment SHALL NOT wrap.
REQ-025 Unused state encodings SHALL return to IDLE on the next enabled edge.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE and sc_key=0, giving no_sol=0, start_decrypt=0, reset_decrypt=0.
REQ-027 Reset asserted mid-search SHALL abort immediately; after release, the search restarts only via start.

Verification
REQ-028 Reset then start=1, enable=1 -> RESET_MANUAL after 1 edge, WAIT_DECRYPT after 2 edges, start_decrypt=1, sc_key=0.
REQ-029 In WAIT_DECRYPT with key 0, dc_invalid=1 -> CHK_KEY, KEY_INC, RESET_DECRYPT (reset_decrypt=1), then WAIT_DECRYPT with sc_key=1.
REQ-030 In WAIT_DECRYPT, dc_done=1 and dc_invalid=0 -> DONE on the next edge; all three outputs are 0; sc_key is held.
REQ-031 Use KEY_MAX=3 and hold dc_invalid=1 -> keys 0,1,2,3 are tried, then NO_SOL with no_sol=1 and sc_key=3.
REQ-032 Drop enable to 0 in KEY_INC for 3 cycles -> state and sc_key frozen; the sequence resumes after enable returns to 1.
REQ-033 Apply dc_done=1 and dc_invalid=1 together -> CHK_KEY; assert reset=0 mid-search -> IDLE and sc_key=0 immediately.

Source files
------------

// File: rtl/rc4_key_cycle.sv
// Sequences candidate RC4 keys through an external decrypt core until one
// decrypts validly (DONE) or the keyspace up to KEY_MAX is exhausted (NO_SOL).
module rc4_key_cycle #(
  parameter logic [23:0] KEY_MAX = 24'h3FFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        enable,
  input  logic        dc_done,
  input  logic        dc_invalid,
  output logic [23:0] sc_key,
  output logic        reset_decrypt,
  output logic        start_decrypt,
  output logic        no_sol
);

  // Upper three bits carry the outputs directly; low nibble keeps codes unique.
  typedef enum logic [6:0] {
    IDLE          = 7'b000_0000,
    RESET_MANUAL  = 7'b001_0001,
    WAIT_DECRYPT  = 7'b010_0010,
    KEY_INC       = 7'b000_0011,
    RESET_DECRYPT = 7'b001_0100,
    DONE          = 7'b000_0101,
    CHK_KEY       = 7'b000_0111,
    NO_SOL        = 7'b100_1000
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [23:0] key_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sc_key <= '0;
    end else if (enable) begin
      state  <= state_next;
      sc_key <= key_next;
    end
  end

  always_comb begin
    state_next = state;
    key_next   = sc_key;
    case (state)
      IDLE:          if (start) state_next = RESET_MANUAL;
      RESET_MANUAL: begin
        key_next   = '0;
        state_next = WAIT_DECRYPT;
      end
      WAIT_DECRYPT: begin
        if (dc_invalid)   state_next = CHK_KEY;
        else if (dc_done) state_next = DONE;
      end
      CHK_KEY:       state_next = (sc_key == KEY_MAX) ? NO_SOL : KEY_INC;
      KEY_INC: begin
        // Guard keeps the key from wrapping even if KEY_INC is reached at KEY_MAX.
        if (sc_key != KEY_MAX) key_next = sc_key + 24'd1;
        state_next = RESET_DECRYPT;
      end
      RESET_DECRYPT: state_next = WAIT_DECRYPT;
      DONE:          state_next = DONE;
      NO_SOL:        state_next = NO_SOL;
      default:       state_next = IDLE;
    endcase
  end

  assign no_sol        = state[6];
  assign start_decrypt = state[5];
  assign reset_decrypt = state[4];

endmodule

// File: tb/tb_rc4_key_cycle.sv
// Directed bench for rc4_key_cycle with KEY_MAX=3; outputs are compared as
// {no_sol, start_decrypt, reset_decrypt, sc_key}.
module tb_rc4_key_cycle;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        enable;
  logic        dc_done;
  logic        dc_invalid;
  logic [23:0] sc_key;
  logic        reset_decrypt;
  logic        start_decrypt;
  logic        no_sol;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  rc4_key_cycle #(.KEY_MAX(24'd3)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .enable        (enable),
    .dc_done       (dc_done),
    .dc_invalid    (dc_invalid),
    .sc_key        (sc_key),
    .reset_decrypt (reset_decrypt),
    .start_decrypt (start_decrypt),
    .no_sol        (no_sol)
  );

  always #5 clk = ~clk;

  function automatic logic [26:0] outv(input logic n, input logic s, input logic r,
                                       input logic [23:0] k);
    return {n, s, r, k};
  endfunction

  task automatic check(input string tag, input logic [26:0] exp);
    logic [26:0] got;
    got = {no_sol, start_decrypt, reset_decrypt, sc_key};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ns/sd/rd/key=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
               tag, got[26], got[25], got[24], got[23:0],
               exp[26], exp[25], exp[24], exp[23:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; enable = 1'b1; dc_done = 1'b0; dc_invalid = 1'b0;
    #2;
    check("reset_state", outv(0, 0, 0, 24'd0));
    step();
    reset = 1'b1;
    step(); step();
    check("idle_hold", outv(0, 0, 0, 24'd0));

    start = 1'b1;
    step(); check("reset_manual", outv(0, 0, 1, 24'd0));
    start = 1'b0;
    step(); check("wait_key0", outv(0, 1, 0, 24'd0));
    step(); check("wait_stay", outv(0, 1, 0, 24'd0));

    dc_invalid = 1'b1;
    step(); check("chk_key0", outv(0, 0, 0, 24'd0));
    dc_invalid = 1'b0;
    step(); check("key_inc0", outv(0, 0, 0, 24'd0));
    step(); check("reset_dec_key1", outv(0, 0, 1, 24'd1));
    step(); check("wait_key1", outv(0, 1, 0, 24'd1));

    dc_invalid = 1'b1;
    step(); check("chk_key1", outv(0, 0, 0, 24'd1));
    dc_invalid = 1'b0;
    step(); check("key_inc1", outv(0, 0, 0, 24'd1));
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); check("enable_freeze", outv(0, 0, 0, 24'd1));
    end
    enable = 1'b1;
    step(); check("resume_reset_dec", outv(0, 0, 1, 24'd2));
    step(); check("wait_key2", outv(0, 1, 0, 24'd2));

    dc_done = 1'b1; dc_invalid = 1'b1;
    step(); check("both_high_chk", outv(0, 0, 0, 24'd2));
    dc_done = 1'b0; dc_invalid = 1'b0;
    step();
    step(); check("invalid_priority", outv(0, 0, 1, 24'd3));
    step(); check("wait_key3", outv(0, 1, 0, 24'd3));

    dc_invalid = 1'b1;
    step(); check("chk_keymax", outv(0, 0, 0, 24'd3));
    step(); check("no_sol", outv(1, 0, 0, 24'd3));
    start = 1'b1; dc_done = 1'b1;
    step(); step(); check("no_sol_terminal", outv(1, 0, 0, 24'd3));
    start = 1'b0; dc_done = 1'b0; dc_invalid = 1'b0;

    #2 reset = 1'b0;
    #1 check("async_reset_nosol", outv(0, 0, 0, 24'd0));
    step(); reset = 1'b1;
    step(); step(); check("idle_after_reset", outv(0, 0, 0, 24'd0));

    start = 1'b1;
    step(); start = 1'b0;
    step(); check("rerun_wait_key0", outv(0, 1, 0, 24'd0));
    dc_invalid = 1'b1;
    step(); dc_invalid = 1'b0;
    step();
    step(); check("rerun_reset_dec", outv(0, 0, 1, 24'd1));
    #2 reset = 1'b0;
    #1 check("async_reset_midsearch", outv(0, 0, 0, 24'd0));
    step(); reset = 1'b1;

    start = 1'b1;
    step(); start = 1'b0;
    step();
    dc_invalid = 1'b1;
    step(); dc_invalid = 1'b0;
    step(); step();
    step(); check("wait_key1_again", outv(0, 1, 0, 24'd1));
    dc_done = 1'b1;
    step(); check("done", outv(0, 0, 0, 24'd1));
    dc_done = 1'b0; dc_invalid = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("done_terminal", outv(0, 0, 0, 24'd1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
